pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_pkg.sv | 11 +
 rtl/pc_fetch_ctrl_if.sv | 15 +
 rtl/pc_fetch_ctrl_fifo.sv | 34 +++
 rtl/pc_fetch_ctrl.sv | 71 +++++++
 tb/tb_pc_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared FSM state, default vectors and fetch-buffer entry type
package pc_fetch_pkg;
  localparam int FETCH_PC_W = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0380;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} fetch_state_e;
  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: decode-side, redirect and instruction-memory signals of the fetch unit
interface pc_fetch_ctrl_if #(parameter int ADDR_W = 32);
  logic stall, redirect_valid, exc_valid;
  logic imem_req, imem_gnt, imem_rvalid, if_valid;
  logic [ADDR_W-1:0] redirect_pc, imem_addr, if_pc;
  logic [31:0] imem_rdata, if_inst;
  modport master(
    input stall, redirect_valid, redirect_pc, exc_valid, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_inst, if_pc
  );
  modport slave(
    output stall, redirect_valid, redirect_pc, exc_valid, imem_gnt, imem_rvalid, imem_rdata,
    input imem_req, imem_addr, if_valid, if_inst, if_pc
  );
endinterface

// File: rtl/pc_fetch_ctrl_fifo.sv
// fetch_fifo: fetched-instruction buffer with wrap-around pointers; flush beats push and pop
module fetch_fifo
  import pc_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign head = mem[rd];
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= push ? wr + AW'(1) : wr;
      rd <= pop ? rd + AW'(1) : rd;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: single-outstanding instruction fetch with redirect/exception kill and fetch buffer
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
  parameter int FB_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  pc_fetch_ctrl_if.master bus
);
  localparam int CW = $clog2(FB_DEPTH) + 1;
  fetch_state_e state;
  logic [ADDR_W-1:0] pc, req_pc, target, addr;
  logic req, kill, redirect, push, pop, valid, room, gnt_ev;
  logic [CW-1:0] count, count_next;
  fetch_entry_t head;
  assign redirect = bus.exc_valid | bus.redirect_valid;
  assign target = bus.exc_valid ? EXC_VECTOR : bus.redirect_pc;
  assign addr = {pc[ADDR_W-1:2], 2'b00};
  assign valid = count != '0;
  assign pop = valid && !bus.stall;
  assign push = state == S_WAIT && bus.imem_rvalid && !kill;
  assign gnt_ev = state == S_REQ && bus.imem_gnt;
  assign count_next = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign room = count_next < CW'(FB_DEPTH);
  fetch_fifo #(.DEPTH(FB_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect),
    .din(fetch_entry_t'{pc: FETCH_PC_W'(req_pc), inst: bus.imem_rdata}),
    .head(head), .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_VECTOR;
      req_pc <= '0;
      kill <= 1'b0;
      req <= 1'b0;
    end else begin
      pc <= redirect ? target : gnt_ev ? pc + ADDR_W'(4) : pc;
      // a redirect while a response is owed marks that response for dropping
      kill <= gnt_ev ? redirect : state == S_WAIT ? !bus.imem_rvalid && (kill || redirect) : kill;
      case (state)
        S_IDLE: if (room) begin
          state <= S_REQ;
          req <= 1'b1;
        end
        S_REQ: if (bus.imem_gnt) begin
          state <= S_WAIT;
          req <= 1'b0;
          req_pc <= addr;
        end
        S_WAIT: if (bus.imem_rvalid) begin
          state <= room ? S_REQ : S_IDLE;
          req <= room;
        end
        default: begin
          state <= S_IDLE;
          req <= 1'b0;
        end
      endcase
    end
  end
  assign bus.imem_req = req;
  assign bus.imem_addr = addr;
  assign bus.if_valid = valid;
  assign bus.if_inst = valid ? head.inst : '0;
  assign bus.if_pc = valid ? ADDR_W'(head.pc) : '0;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed fetch scenarios plus randomized traffic against a transaction-level model
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EXC = 32'h0000_0380;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pc_fetch_ctrl_if #(.ADDR_W(32)) bus ();
  pc_fetch_ctrl #(.ADDR_W(32), .RESET_VECTOR(RV), .EXC_VECTOR(EXC), .FB_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int total = 0, bad = 0;
  int gnt_pct = 100, rv_pct = 100;
  logic force_rv = 1'b0, armed = 1'b0;
  logic [31:0] salt = '0;
  logic [31:0] m_pc = '0, out_addr = '0;
  logic outstanding = 1'b0, out_killed = 1'b0;
  ent_t q[$];
  logic [31:0] popped[$];
  logic s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: drive memory side, check outputs at negedge, advance the model at posedge
  task automatic tick();
    logic g_ev, r_ev, p_ev, rd;
    logic [31:0] tgt;
    bus.imem_gnt = $urandom_range(99) < gnt_pct;
    bus.imem_rvalid = force_rv || (outstanding && $urandom_range(99) < rv_pct);
    bus.imem_rdata = (outstanding && !force_rv) ? (out_addr ^ salt) : 32'hBAD0_0BAD;
    @(negedge clk);
    s_req = bus.imem_req;
    s_addr = bus.imem_addr;
    s_valid = bus.if_valid;
    s_pc = bus.if_pc;
    s_inst = bus.if_inst;
    if (armed) begin
      chk("if_valid", 32'(s_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("if_pc", s_pc, q[0].pc);
        chk("if_inst", s_inst, q[0].inst);
      end
      if (s_req) begin
        chk("imem_addr", s_addr, {m_pc[31:2], 2'b00});
        chk("one_outstanding", 32'(outstanding), 32'd0);
      end
    end
    g_ev = s_req && bus.imem_gnt;
    r_ev = bus.imem_rvalid && outstanding;
    p_ev = q.size() != 0 && !bus.stall;
    rd = bus.exc_valid || bus.redirect_valid;
    tgt = bus.exc_valid ? EXC : bus.redirect_pc;
    @(posedge clk);
    if (rst) begin
      m_pc = RV;
      q.delete();
      outstanding = 1'b0;
      out_killed = 1'b0;
      armed = 1'b1;
    end else begin
      if (p_ev) begin
        popped.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (r_ev) begin
        if (!out_killed) q.push_back('{pc: out_addr, inst: out_addr ^ salt});
        outstanding = 1'b0;
      end
      if (g_ev) begin
        outstanding = 1'b1;
        out_killed = 1'b0;
        out_addr = {m_pc[31:2], 2'b00};
        m_pc = m_pc + 32'd4;
      end
      if (rd) begin
        q.delete();
        m_pc = tgt;
        if (outstanding) out_killed = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.exc_valid = 1'b0;
    bus.redirect_pc = '0;
    force_rv = 1'b0;
    gnt_pct = 100;
    rv_pct = 100;
    tick();
    tick();
    rst = 1'b0;
    popped.delete();
  endtask

  initial begin
    // reset values, first request timing and steady sequential stream
    do_reset();
    tick();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_inst", s_inst, 32'd0);
    chk("rst_pc", s_pc, 32'd0);
    tick();
    chk("first_req", 32'(s_req), 32'd1);
    chk("first_addr", s_addr, RV);
    tick();
    chk("lat_valid_c3", 32'(s_valid), 32'd0);
    tick();
    chk("lat_valid_c4", 32'(s_valid), 32'd1);
    chk("lat_pc_c4", s_pc, 32'h0);
    chk("lat_inst_c4", s_inst, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("seq_pops", popped.size(), 32'd5);
    chk("seq_pop1", popped[1], 32'h4);
    chk("seq_pop4", popped[4], 32'h10);
    // stall fills the buffer and holds the head
    do_reset();
    bus.stall = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_req", 32'(s_req), 32'd0);
    chk("stall_valid", 32'(s_valid), 32'd1);
    chk("stall_head", s_pc, 32'h0);
    chk("stall_depth", q.size(), 32'd2);
    bus.stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("drain_0", popped[0], 32'h0);
    chk("drain_1", popped[1], 32'h4);
    chk("drain_2", popped[2], 32'h8);
    // redirect during WAIT
    do_reset();
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    rv_pct = 0;
    tick();
    chk("redir_pre_valid", 32'(s_valid), 32'd1);
    bus.redirect_valid = 1'b0;
    rv_pct = 100;
    tick();
    chk("redir_flush", 32'(s_valid), 32'd0);
    chk("redir_kill_req", 32'(s_req), 32'd0);
    tick();
    chk("redir_req", 32'(s_req), 32'd1);
    chk("redir_addr", s_addr, 32'h100);
    tick();
    tick();
    chk("redir_pc", s_pc, 32'h100);
    chk("redir_inst", s_inst, 32'h100);
    // exception beats redirect
    do_reset();
    bus.exc_valid = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.exc_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    chk("exc_req", 32'(s_req), 32'd1);
    chk("exc_addr", s_addr, EXC);
    // grant withheld, then redirect to an unaligned target
    do_reset();
    gnt_pct = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h203;
      end
      tick();
      chk("nognt_req", 32'(s_req), 32'd1);
      chk("nognt_addr", s_addr, 32'h0);
    end
    bus.redirect_valid = 1'b0;
    gnt_pct = 100;
    tick();
    chk("align_addr", s_addr, 32'h200);
    tick();
    tick();
    chk("align_pc", s_pc, 32'h200);
    chk("align_next", s_addr, 32'h204);
    // reset in WAIT with late response
    do_reset();
    tick();
    tick();
    rst = 1'b1;
    rv_pct = 0;
    tick();
    rst = 1'b0;
    force_rv = 1'b1;
    tick();
    chk("late_req", 32'(s_req), 32'd0);
    chk("late_valid", 32'(s_valid), 32'd0);
    force_rv = 1'b0;
    rv_pct = 100;
    tick();
    chk("late_restart", s_addr, RV);
    chk("late_restart_req", 32'(s_req), 32'd1);
    tick();
    tick();
    chk("late_pc", s_pc, RV);
    // randomized traffic
    salt = $urandom;
    do_reset();
    gnt_pct = 70;
    rv_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(99);
      bus.stall = $urandom_range(9) < 3;
      bus.redirect_valid = r < 5;
      bus.exc_valid = r >= 97 || r == 4;
      bus.redirect_pc = $urandom;
      rst = $urandom_range(199) == 0;
      tick();
    end
    chk("rand_liveness", 32'(popped.size() > 100), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
